// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle FSM (slave side) and the datapath (master side).
// The master supplies opcode and memory handshake; the slave returns datapath strobes.
interface main_fsm_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic               mem_ready;
  logic               Branch;
  logic               PCUpdate;
  logic               RegWrite;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               AdrSrc;
  logic [1:0]         ALUOp;
  logic               illegal_instr;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    output op, mem_ready,
    input  Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, AdrSrc, ALUOp, illegal_instr, state_dbg
  );

  modport slave (
    input  op, mem_ready,
    output Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, AdrSrc, ALUOp, illegal_instr, state_dbg
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM driving datapath strobes and ALUOp, stalling on mem_ready.
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  main_fsm_if.slave bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    JAL      = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic        branch, pcUpdate, regWrite, memWrite, irWrite, adrSrc;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB, aluOp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = FETCH;
    branch    = 1'b0;
    pcUpdate  = 1'b0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    adrSrc    = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    case (state_q)
      FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = bus.mem_ready;
        pcUpdate  = bus.mem_ready;
        state_d   = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here from OldPC + ImmExt.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSrc  = 1'b1;
        state_d = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        state_d  = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
        state_d = ALUWB;
      end
      JAL: begin
        aluSrcA  = 2'b01;
        aluSrcB  = 2'b10;
        pcUpdate = 1'b1;
        state_d  = ALUWB;
      end
      ALUWB: begin
        regWrite = 1'b1;
      end
      BEQ: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      TRAP: begin
        state_d = TRAP;
      end
`endif
      default: begin
        state_d = FETCH;
      end
    endcase
  end

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Flag rises on the same edge that enters TRAP and only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state_d == TRAP);
  end

  assign bus.illegal_instr = illegal_q;
`else
  assign bus.illegal_instr = 1'b0;
`endif

  assign bus.Branch    = branch;
  assign bus.PCUpdate  = pcUpdate;
  assign bus.RegWrite  = regWrite;
  assign bus.MemWrite  = memWrite;
  assign bus.IRWrite   = irWrite;
  assign bus.AdrSrc    = adrSrc;
  assign bus.ResultSrc = resultSrc;
  assign bus.ALUSrcA   = aluSrcA;
  assign bus.ALUSrcB   = aluSrcB;
  assign bus.ALUOp     = aluOp;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
Multicycle RISC-V control FSM sitting directly upstream of the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath mux/enable strobes and the 2-bit ALUOp that the ALU decoder turns into ALUControl. A memory-ready handshake lets it stall on slow instruction/data memory.

Parameters:
STATE_W, 4, width of state register and debug state output (fixed 4; 11–12 states used)

Ports:
clk  input  1  system clock, all flops rising-edge
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  7  instruction opcode field instr[6:0], from instruction register
mem_ready  input  1  memory completed current access this cycle
Branch  output  1  branch-compare cycle; PC loads if Zero
PCUpdate  output  1  unconditional PC write
RegWrite  output  1  register file write enable
MemWrite  output  1  data memory write request
IRWrite  output  1  instruction register / OldPC load
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 (A)
ALUSrcB  output  2  00 rs2 (WriteData), 01 ImmExt, 10 constant 4
AdrSrc  output  1  0 PC, 1 Result as memory address
ALUOp  output  2  00 add, 01 subtract (beq), 10 funct-decoded
illegal_instr  output  1  sticky illegal-opcode flag (see Optional Feature)
state_dbg  output  4  current state encoding

Behaviour:
- Moore FSM, one state register; outputs are a combinational function of state, plus mem_ready gating where noted. Any output not listed for a state is 0.
- Reset: state=FETCH(0) immediately and asynchronously. Outputs during reset are the FETCH decode: IRWrite=PCUpdate=mem_ready; ALUSrcB=10; ResultSrc=10; all others 0.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, JAL 8, ALUWB 9, BEQ 10, TRAP 11.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when mem_ready=1. The FSM holds in FETCH while mem_ready=0. When mem_ready=1, it goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precomputed). Next state is selected by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> illegal handling
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE. op is sampled from the IR, which is stable after FETCH.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in state. Holds until mem_ready=1, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- Latency with mem_ready held 1:
  - R-type, I-ALU, jal: 4 cycles
  - beq: 3 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - Each stall cycle adds 1.
- Reset asserted in any state (mid-instruction, mid-stall): next observable state is FETCH. No RegWrite or MemWrite is emitted after reset assertion.
- Unreachable encodings 12–15: next state FETCH, outputs all 0.

Optional Feature:
- Macro: MAIN_FSM_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised op in DECODE goes to TRAP.
  - TRAP drives all strobes 0 and illegal_instr=1.
  - The FSM stays in TRAP until reset.
  - illegal_instr is registered and clears on reset.
- Undefined:
  - An unrecognised op in DECODE goes to FETCH, i.e. it is treated as a nop costing 2 cycles.
  - illegal_instr is tied 0 and TRAP is unreachable.

Test Plan:
- Reset asserted mid-EXECUTER, released, mem_ready=1 -> state_dbg=0, IRWrite=1, PCUpdate=1, RegWrite=0.
- op=0110011, mem_ready=1 -> states 0,1,6,9,0. ALUOp=10 in state 6; RegWrite=1 only in state 9.
- op=0000011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> states 0,0,0,1,2,3,3,3,3,4,0. IRWrite pulses exactly once; RegWrite=1 with ResultSrc=01 in state 4.
- op=0100011, mem_ready=1 -> states 0,1,2,5,0. MemWrite=1 only in state 5 with AdrSrc=1. RegWrite never asserted.
- op=1100011 -> states 0,1,10,0. ALUOp=01 and Branch=1 in state 10. op=1101111 -> states 0,1,8,9,0 with PCUpdate=1 in state 8.
- op=1111111 -> with MAIN_FSM_ILLEGAL_TRAP_EN: states 0,1,11,11…, illegal_instr=1 until reset. Without the macro: states 0,1,0 and illegal_instr=0.
